mvm_instr_seq: RTL and testbench
================================

# mvm_instr_seq

Instruction sequencer that sits directly upstream of the matrix-vector PE. It holds a small program of 80-bit layer instructions, written by the host before a run. On `start` it fetches the instructions in order and issues each one over the PE's valid/ready instruction port. Issue stops after the first SAVE instruction; the run completes when the PE reports `save_ok`.

## Interface
Parameters:
- `PROG_DEPTH`, 16: program memory entries; must be a power of two.
- `PC_W`, $clog2(PROG_DEPTH): program counter width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `prog_we`  in  1  program write strobe; ignored while `busy`.
- `prog_addr`  in  PC_W  program write address.
- `prog_dat`  in  80  program write data.
- `start`  in  1  one-cycle pulse; sampled only in IDLE, DONE or ERR.
- `abort`  in  1  returns the block to IDLE from any state.
- `valid`  out  1  instruction valid to the PE.
- `ready`  in  1  PE accepts the instruction.
- `instruction`  out  80  instruction to the PE.
- `save_ok`  in  1  PE pulse: save phase complete.
- `busy`  out  1  high from the cycle after an accepted start until DONE, ERR or IDLE is reached.
- `done`  out  1  level; high in DONE.
- `err`  out  1  level; high in ERR.
- `err_pc`  out  PC_W  pc of the offending entry; valid while `err`.
- `issued_cnt`  out  PC_W+1  instructions accepted by the PE in the current run.

## Operation
Instruction fields:
- [79:76] OP: 1 = first MVM, 2 = MVM, 3 = SAVE; any other value is illegal.
- [71:64] DIMi−1.
- [63:56] DIMo−1.
- [47:32] bias base address.
- [31:16] weight base address.
- Other bits are passed through unchanged.

State machine states: IDLE, FETCH, ISSUE, WAIT_SAVE, DONE, ERR.
- IDLE / DONE / ERR, `start`: pc←0, `issued_cnt`←0, clear `done`/`err`, go to FETCH.
- FETCH: assert the synchronous memory read at pc; go to ISSUE with the word registered into `instruction`.
- ISSUE, entering:
  - OP illegal → ERR, `err_pc`←pc, `valid` never asserted.
  - OP=1 at pc≠0 → ERR (a first-layer instruction is legal only as entry 0).
  - Otherwise assert `valid`.
- ISSUE with `valid & ready`, OP≠3: `issued_cnt`++. If pc=PROG_DEPTH−1 → ERR (no SAVE found). Otherwise pc++ and go to FETCH.
- ISSUE with `valid & ready`, OP=3: `issued_cnt`++, go to WAIT_SAVE.
- WAIT_SAVE, `save_ok`: go to DONE.
- `abort`: IDLE in the next cycle; `valid` drops immediately (registered); pc and counters clear. `abort` takes priority over `start` and `save_ok`.
- `save_ok` outside WAIT_SAVE is ignored.
- Program writes while `busy` are dropped. Writes in other states take effect for the next fetch.

## Timing
- Reset values: state=IDLE, `valid`=0, `instruction`=0, `busy`=0, `done`=0, `err`=0, `err_pc`=0, `issued_cnt`=0, pc=0.
- All outputs are registered.
- `start` to the first `valid`: 2 cycles (FETCH, then the ISSUE entry).
- After a handshake, `valid` is low for exactly 1 cycle (FETCH), then the next word is presented. Peak rate: one instruction per 2 cycles.
- AXI-style hold rule: once `valid` is asserted, `instruction` is stable and `valid` stays high until `ready`. `ready` may be high before `valid`.
- `done` / `err` rise the cycle after the triggering event and hold until `start`, `abort` or `rst`.
- `rst` mid-run: the next edge forces all reset values; no partial handshake completes.

## Structure
Shared package `mvm_pkg`:
- OP codes `OP_MVM_FIRST`, `OP_MVM`, `OP_SAVE`.
- Field bit positions.
- `instr_t` packed struct: op, rsvd, dimi_m1, dimo_m1, bias_base, wgt_base, rsvd.
- State enum.

Sub-module `instr_ram`: single-port write / single-port read, synchronous read, 1-cycle latency, no reset on the array. The sequencer FSM stays in the top module.

## Test plan
- Load {1000_1F63_0000_0000_0000, 2000_637F_0004_0080_0000, 2000_7F07_0008_0210_0000, 3000_0007_0000_0000_0000}, `start`, `ready` always high:
  - Four handshakes, on cycles 2, 4, 6 and 8 after `start`.
  - `busy`=1, `issued_cnt`=4.
  - `save_ok` 50 cycles later → `done`=1, `busy`=0.
- Same program, `ready` low for 20 cycles per instruction:
  - `valid` held and `instruction` unchanged throughout each stall.
  - Handshake order preserved.
- Entry 1 OP=0x5:
  - One handshake, then `err`=1 with `err_pc`=1.
  - `valid` never asserts for entry 1.
- All 16 entries OP=2, no SAVE: 16 handshakes, then `err`=1 with `err_pc`=15.
- Program with OP=1 at entry 2: `err` after 2 handshakes, `err_pc`=2.
- `abort` while stalled in ISSUE:
  - Next cycle `valid`=0, IDLE, `issued_cnt`=0.
  - A following `start` reruns from entry 0.
  - `prog_we` during the run is ignored (verify by readback of the issued words).

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector PE instruction path.
// Contents: opcode values, instruction field positions, the packed 80-bit
// instruction layout, the sequencer state encoding and an opcode legality helper.
package mvm_pkg;

    localparam int unsigned INSTR_W = 80;

    localparam logic [3:0] OP_MVM_FIRST = 4'd1;
    localparam logic [3:0] OP_MVM       = 4'd2;
    localparam logic [3:0] OP_SAVE      = 4'd3;

    // Field LSB positions within the 80-bit instruction word.
    localparam int unsigned OP_LSB   = 76;
    localparam int unsigned DIMI_LSB = 64;
    localparam int unsigned DIMO_LSB = 56;
    localparam int unsigned BIAS_LSB = 32;
    localparam int unsigned WGT_LSB  = 16;

    typedef struct packed {
        logic [3:0]  op;         // [79:76]
        logic [3:0]  rsvd_hi;    // [75:72]
        logic [7:0]  dimi_m1;    // [71:64]
        logic [7:0]  dimo_m1;    // [63:56]
        logic [7:0]  rsvd_mid;   // [55:48]
        logic [15:0] bias_base;  // [47:32]
        logic [15:0] wgt_base;   // [31:16]
        logic [15:0] rsvd_lo;    // [15:0]
    } instr_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitSave,
        StDone,
        StErr
    } seq_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_MVM_FIRST) || (op == OP_MVM) || (op == OP_SAVE);
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Program memory for the instruction sequencer.
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata registered
// read data (1-cycle latency). The array has no reset.
module instr_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 80
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mvm_instr_seq.sv
// Instruction sequencer feeding the matrix-vector PE.
// Ports: clk, rst (sync, active-high); prog_we/prog_addr/prog_dat host program
// writes (dropped while busy); start/abort run control; valid/ready/instruction
// PE issue handshake; save_ok PE completion pulse; busy/done/err/err_pc/issued_cnt
// run status. All outputs are registered.
module mvm_instr_seq
    import mvm_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [79:0]        prog_dat,
    input  logic               start,
    input  logic               abort,
    output logic               valid,
    input  logic               ready,
    output logic [79:0]        instruction,
    input  logic               save_ok,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PC_W-1:0]    err_pc,
    output logic [PC_W:0]      issued_cnt
);

    localparam logic [PC_W-1:0] LastPc = PC_W'(PROG_DEPTH - 1);

    seq_state_t      state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] rd_addr;
    logic [79:0]     rd_data;
    instr_t          rd_word;
    instr_t          cur_word;

    assign rd_word  = instr_t'(rd_data);
    assign cur_word = instr_t'(instruction);

    // FETCH is entered either from a start (pc=0) or from an ISSUE handshake
    // (pc+1). Presenting that address one edge early puts the word on rd_data
    // during FETCH, so the ISSUE entry can decide valid from it.
    always_comb begin
        rd_addr = '0;
        if (state_q == StIssue) begin
            rd_addr = pc_q + 1'b1;
        end
    end

    instr_ram #(
        .DEPTH (PROG_DEPTH),
        .AW    (PC_W),
        .DW    (INSTR_W)
    ) u_instr_ram (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_dat),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            valid       <= 1'b0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_pc      <= '0;
            issued_cnt  <= '0;
        end else if (abort) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_pc     <= '0;
            issued_cnt <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q    <= StFetch;
                        pc_q       <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        err_pc     <= '0;
                        issued_cnt <= '0;
                    end
                end
                StFetch: begin
                    // A first-layer instruction is only legal as entry 0.
                    if (!op_legal(rd_word.op) ||
                        (rd_word.op == OP_MVM_FIRST && pc_q != '0)) begin
                        state_q <= StErr;
                        err     <= 1'b1;
                        err_pc  <= pc_q;
                        busy    <= 1'b0;
                    end else begin
                        state_q     <= StIssue;
                        instruction <= rd_data;
                        valid       <= 1'b1;
                    end
                end
                StIssue: begin
                    if (valid && ready) begin
                        valid      <= 1'b0;
                        issued_cnt <= issued_cnt + 1'b1;
                        if (cur_word.op == OP_SAVE) begin
                            state_q <= StWaitSave;
                        end else if (pc_q == LastPc) begin
                            // Ran off the end of the program without a SAVE.
                            state_q <= StErr;
                            err     <= 1'b1;
                            err_pc  <= pc_q;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= StFetch;
                            pc_q    <= pc_q + 1'b1;
                        end
                    end
                end
                StWaitSave: begin
                    if (save_ok) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_instr_seq.sv
module tb_mvm_instr_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [79:0] prog_dat;
    logic        start;
    logic        abort;
    logic        valid;
    logic        ready;
    logic [79:0] instruction;
    logic        save_ok;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  err_pc;
    logic [4:0]  issued_cnt;

    mvm_instr_seq #(.PROG_DEPTH(16), .PC_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_dat    (prog_dat),
        .start       (start),
        .abort       (abort),
        .valid       (valid),
        .ready       (ready),
        .instruction (instruction),
        .save_ok     (save_ok),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_pc      (err_pc),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] instr;
        int          cyc;   // -1: handshake cycle not checked
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [79:0] prog4 [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        chk_cnt++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks the hold rule.
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_abort = 1'b0;
    logic [79:0] prev_i = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r && !prev_abort) begin
                check("hold_valid", valid, 1);
                check("hold_instr", instruction, prev_i);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    note_fail($sformatf("unexpected_handshake instr=%0h", instruction));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hs_instr", instruction, e.instr);
                    if (e.cyc >= 0) check("hs_cycle", cyc, e.cyc);
                end
            end
            prev_v = valid;
            prev_r = ready;
        end
        prev_i     = instruction;
        prev_abort = abort;
    end

    task automatic push(input logic [79:0] w, input int c);
        exp_t e;
        e.instr = w;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [79:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = a; prog_dat = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic load_prog4();
        for (int i = 0; i < 4; i++) prog_write(4'(i), prog4[i]);
    endtask

    // Returns the cycle index in which start was high.
    task automatic do_start(output int k);
        @(posedge clk); #1;
        start = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_save_ok();
        @(posedge clk); #1;
        save_ok = 1'b1;
        @(posedge clk); #1;
        save_ok = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        @(negedge clk);
        while (!valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!valid) note_fail("wait_valid timeout");
    endtask

    task automatic wait_flag(input bit want_err, input int max);
        int n = 0;
        @(negedge clk);
        while (!(want_err ? err : done) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!(want_err ? err : done)) note_fail(want_err ? "wait_err timeout" : "wait_done timeout");
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int k;
        prog4[0] = 80'h1000_1F63_0000_0000_0000;
        prog4[1] = 80'h2000_637F_0004_0080_0000;
        prog4[2] = 80'h2000_7F07_0008_0210_0000;
        prog4[3] = 80'h3000_0007_0000_0000_0000;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_dat = '0;
        start = 1'b0; abort = 1'b0; ready = 1'b0; save_ok = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_pc", err_pc, 0);
        check("rst_cnt", issued_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: four-entry program, ready always high, one issue per 2 cycles.
        load_prog4();
        ready = 1'b1;
        do_start(k);
        for (int i = 0; i < 4; i++) push(prog4[i], k + 2 + 2 * i);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_cnt", issued_cnt, 4);
        check("t1_done_early", done, 0);
        repeat (50) @(posedge clk);
        save_ok = 1'b0;
        pulse_save_ok();
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check_drained("t1_drained");

        // 2: same program, 20-cycle stall on every instruction.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push(prog4[i], -1);
        do_start(k);
        @(negedge clk);
        check("t2_done_cleared", done, 0);
        for (int i = 0; i < 4; i++) begin
            wait_valid(10);
            repeat (20) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk); #1;
            ready = 1'b0;
        end
        pulse_save_ok();
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_cnt", issued_cnt, 4);
        check_drained("t2_drained");

        // 3: illegal opcode at entry 1.
        prog_write(4'd1, 80'h5000_0000_0000_0000_0000);
        ready = 1'b1;
        push(prog4[0], -1);
        do_start(k);
        wait_flag(1'b1, 20);
        check("t3_err_pc", err_pc, 1);
        check("t3_cnt", issued_cnt, 1);
        check("t3_busy", busy, 0);
        check_drained("t3_drained");

        // 4: sixteen MVMs, no SAVE.
        for (int i = 0; i < 16; i++) prog_write(4'(i), {4'h2, 68'h0, 8'(i)});
        for (int i = 0; i < 16; i++) push({4'h2, 68'h0, 8'(i)}, -1);
        do_start(k);
        @(negedge clk);
        check("t4_err_cleared", err, 0);
        wait_flag(1'b1, 60);
        check("t4_err_pc", err_pc, 15);
        check("t4_cnt", issued_cnt, 16);
        check_drained("t4_drained");

        // 5: first-layer opcode at entry 2.
        prog_write(4'd0, prog4[0]);
        prog_write(4'd1, prog4[1]);
        prog_write(4'd2, 80'h1000_0101_0000_0000_0000);
        push(prog4[0], -1);
        push(prog4[1], -1);
        do_start(k);
        wait_flag(1'b1, 20);
        check("t5_err_pc", err_pc, 2);
        check("t5_cnt", issued_cnt, 2);
        check_drained("t5_drained");

        // 6: abort while stalled; program writes during the run are dropped.
        load_prog4();
        ready = 1'b0;
        do_start(k);
        wait_valid(10);
        prog_write(4'd1, 80'hDEAD_BEEF_0000_0000_0000);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_valid", valid, 0);
        check("t6_busy", busy, 0);
        check("t6_cnt", issued_cnt, 0);
        check("t6_err", err, 0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) push(prog4[i], -1);
        do_start(k);
        repeat (12) @(posedge clk);
        pulse_save_ok();
        @(negedge clk);
        check("t6_done", done, 1);
        check("t6_cnt_end", issued_cnt, 4);
        check_drained("t6_drained");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
